// File: rtl/literal_width_adapter_pkg.sv
// Shared definitions for the literal width adapter: the 2-bit fill-mode type
// and its encodings.
package literal_width_adapter_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_ZERO = 2'd0;  // pad with zeros
    localparam mode_t MODE_SIGN = 2'd1;  // replicate leftmost input bit
    localparam mode_t MODE_ONES = 2'd2;  // pad with ones
    localparam mode_t MODE_SAT  = 2'd3;  // unsigned saturate on truncation

endpackage

// File: rtl/literal_width_adapter_skid_buffer2.sv
// Two-entry FIFO-ordered valid/ready buffer. The head entry drives the output
// directly from a register, so an accepted beat is visible the next cycle.
// The input ready is registered and means "not full after this edge".
module literal_width_adapter_skid_buffer2
    import literal_width_adapter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] slot0;  // head of queue, drives the output
    logic [W-1:0] slot1;  // second entry, queued behind the head
    logic [1:0]   count;
    logic [1:0]   count_nxt;
    logic         push;
    logic         pop;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = slot0;

    // Next occupancy; push and pop together leave it unchanged.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 2'd1;
        end else if (pop && !push) begin
            count_nxt = count - 2'd1;
        end
    end

    // Occupancy and registered ready; ready stays low while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            in_ready <= 1'b0;
        end else begin
            count    <= count_nxt;
            in_ready <= (count_nxt != 2'd2);
        end
    end

    // Entry storage: a pop shifts slot1 forward; a push lands in the first
    // slot that will be free after this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (pop) begin
                slot0 <= slot1;
            end
            if (push) begin
                if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
                    slot0 <= in_data;
                end else begin
                    slot1 <= in_data;
                end
            end
        end
    end

endmodule

// File: rtl/literal_width_adapter.sv
// Streaming width converter. Each accepted beat is left-padded (narrow input)
// or left-truncated (wide input) to OUT_W according to its fill mode, tagged
// with a truncation flag, and queued in a two-entry skid buffer. A saturating
// counter tallies accepted beats that lost information.
module literal_width_adapter
    import literal_width_adapter_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 12,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  mode_t            in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_trunc,
    output logic [CNT_W-1:0] trunc_cnt,
    input  logic             cnt_clr
);

    localparam int MAX_W = (IN_W > OUT_W) ? IN_W : OUT_W;

    // Returns {trunc, data}. The input is first widened to MAX_W with the
    // mode's fill bit; the bits above OUT_W are then the ones a truncation
    // drops (none when IN_W <= OUT_W, which forces trunc to 0).
    function automatic logic [OUT_W:0] convert(input logic [IN_W-1:0] d,
                                               input mode_t           m);
        logic [MAX_W-1:0] w;
        logic [OUT_W-1:0] r;
        logic             fill;
        logic             any1;
        logic             all1;
        logic             mism;
        logic             t;
        w    = MAX_W'(d);
        fill = (m == MODE_SIGN) ? d[IN_W-1] : (m == MODE_ONES);
        for (int i = IN_W; i < MAX_W; i++) begin
            w[i] = fill;
        end
        any1 = 1'b0;
        all1 = 1'b1;
        mism = 1'b0;
        for (int i = OUT_W; i < MAX_W; i++) begin
            any1 = any1 | w[i];
            all1 = all1 & w[i];
            mism = mism | (w[i] != w[OUT_W-1]);
        end
        r = w[OUT_W-1:0];
        case (m)
            MODE_ZERO: t = any1;
            MODE_SIGN: t = mism;
            MODE_ONES: t = ~all1;
            default: begin
                t = any1;
                if (any1) begin
                    r = '1;
                end
            end
        endcase
        return {t, r};
    endfunction

    logic [OUT_W:0] conv;
    logic [OUT_W:0] buf_out;
    logic           accept;

    assign conv      = convert(in_data, in_mode);
    assign accept    = in_valid & in_ready;
    assign out_data  = buf_out[OUT_W-1:0];
    assign out_trunc = buf_out[OUT_W];

    literal_width_adapter_skid_buffer2 #(
        .W (OUT_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (conv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

    // Truncation event counter: clear wins over a same-cycle increment,
    // and the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trunc_cnt <= '0;
        end else if (cnt_clr) begin
            trunc_cnt <= '0;
        end else if (accept && conv[OUT_W] && (trunc_cnt != '1)) begin
            trunc_cnt <= trunc_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_literal_width_adapter.sv
// Directed bench for literal_width_adapter. Instance A widens 8->12 bits;
// instance B narrows 16->12 bits with a 2-bit truncation counter.
module tb_literal_width_adapter;
    import literal_width_adapter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_trunc, a_cnt_clr;
    logic [7:0]  a_in_data;
    mode_t       a_in_mode;
    logic [11:0] a_out_data;
    logic [15:0] a_trunc_cnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_trunc, b_cnt_clr;
    logic [15:0] b_in_data;
    mode_t       b_in_mode;
    logic [11:0] b_out_data;
    logic [1:0]  b_trunc_cnt;

    literal_width_adapter #(.IN_W(8), .OUT_W(12), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_trunc(a_out_trunc), .trunc_cnt(a_trunc_cnt), .cnt_clr(a_cnt_clr)
    );

    literal_width_adapter #(.IN_W(16), .OUT_W(12), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_trunc(b_out_trunc), .trunc_cnt(b_trunc_cnt), .cnt_clr(b_cnt_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d, input mode_t m,
                          input logic [11:0] ed, input logic et, input string tag);
        chk({tag, "_rdy"}, 32'(a_in_ready), 32'd1);
        a_in_valid = 1'b1; a_in_data = d; a_in_mode = m;
        tick();
        a_in_valid = 1'b0;
        chk({tag, "_vld"}, 32'(a_out_valid), 32'd1);
        chk({tag, "_data"}, 32'(a_out_data), 32'(ed));
        chk({tag, "_trunc"}, 32'(a_out_trunc), 32'(et));
        tick();
    endtask

    task automatic send_b(input logic [15:0] d, input mode_t m,
                          input logic [11:0] ed, input logic et, input string tag);
        chk({tag, "_rdy"}, 32'(b_in_ready), 32'd1);
        b_in_valid = 1'b1; b_in_data = d; b_in_mode = m;
        tick();
        b_in_valid = 1'b0;
        chk({tag, "_vld"}, 32'(b_out_valid), 32'd1);
        chk({tag, "_data"}, 32'(b_out_data), 32'(ed));
        chk({tag, "_trunc"}, 32'(b_out_trunc), 32'(et));
        tick();
    endtask

    initial begin
        a_in_valid = 1'b0; a_in_data = '0; a_in_mode = MODE_ZERO; a_out_ready = 1'b1; a_cnt_clr = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_mode = MODE_ZERO; b_out_ready = 1'b1; b_cnt_clr = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_a_vld", 32'(a_out_valid), 32'd0);
        chk("rst_a_rdy", 32'(a_in_ready), 32'd0);
        chk("rst_a_data", 32'(a_out_data), 32'd0);
        chk("rst_a_trunc", 32'(a_out_trunc), 32'd0);
        chk("rst_a_cnt", 32'(a_trunc_cnt), 32'd0);
        chk("rst_b_rdy", 32'(b_in_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("rel_a_rdy_low", 32'(a_in_ready), 32'd0);
        tick();
        chk("rel_a_rdy_high", 32'(a_in_ready), 32'd1);
        chk("rel_b_rdy_high", 32'(b_in_ready), 32'd1);

        // Extension 8 -> 12
        send_a(8'h85, MODE_ZERO, 12'h085, 1'b0, "ext_zero_85");
        send_a(8'h85, MODE_SIGN, 12'hF85, 1'b0, "ext_sign_85");
        send_a(8'h85, MODE_ONES, 12'hF85, 1'b0, "ext_ones_85");
        send_a(8'h35, MODE_SIGN, 12'h035, 1'b0, "ext_sign_35");
        send_a(8'h35, MODE_ONES, 12'hF35, 1'b0, "ext_ones_35");
        send_a(8'h85, MODE_SAT,  12'h085, 1'b0, "ext_sat_85");

        // Truncation 16 -> 12 and counter
        send_b(16'h0ABC, MODE_ZERO, 12'hABC, 1'b0, "tr_zero_0abc");
        send_b(16'h1ABC, MODE_ZERO, 12'hABC, 1'b1, "tr_zero_1abc");
        send_b(16'h1ABC, MODE_SAT,  12'hFFF, 1'b1, "tr_sat_1abc");
        chk("cnt_two", 32'(b_trunc_cnt), 32'd2);
        b_cnt_clr = 1'b1;
        tick();
        b_cnt_clr = 1'b0;
        chk("cnt_clr", 32'(b_trunc_cnt), 32'd0);
        send_b(16'hFABC, MODE_SIGN, 12'hABC, 1'b0, "tr_sign_fabc");
        send_b(16'hF3BC, MODE_SIGN, 12'h3BC, 1'b1, "tr_sign_f3bc");
        send_b(16'hFABC, MODE_ONES, 12'hABC, 1'b0, "tr_ones_fabc");
        send_b(16'h0ABC, MODE_ONES, 12'hABC, 1'b1, "tr_ones_0abc");
        send_b(16'h0ABC, MODE_SAT,  12'hABC, 1'b0, "tr_sat_0abc");
        chk("cnt_mixed", 32'(b_trunc_cnt), 32'd2);
        b_cnt_clr = 1'b1;
        tick();
        b_cnt_clr = 1'b0;

        // Counter saturation at 3 for a 2-bit counter
        for (int k = 0; k < 5; k++) begin
            send_b(16'h1000, MODE_ZERO, 12'h000, 1'b1, "sat_beat");
            chk("sat_cnt", 32'(b_trunc_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
        end
        // Clear wins over a same-cycle truncating beat
        b_in_valid = 1'b1; b_in_data = 16'h2345; b_in_mode = MODE_ZERO; b_cnt_clr = 1'b1;
        tick();
        b_in_valid = 1'b0; b_cnt_clr = 1'b0;
        chk("clr_prio_cnt", 32'(b_trunc_cnt), 32'd0);
        chk("clr_prio_data", 32'(b_out_data), 32'h345);
        chk("clr_prio_trunc", 32'(b_out_trunc), 32'd1);
        tick();

        // Backpressure: four beats, consumer stalled for three edges
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h11; a_in_mode = MODE_ZERO;
        tick();
        chk("bp_first_data", 32'(a_out_data), 32'h011);
        chk("bp_rdy_after1", 32'(a_in_ready), 32'd1);
        a_in_data = 8'h22;
        tick();
        chk("bp_rdy_after2", 32'(a_in_ready), 32'd0);
        chk("bp_hold1", 32'(a_out_data), 32'h011);
        a_in_data = 8'h33;
        tick();
        chk("bp_rdy_stall", 32'(a_in_ready), 32'd0);
        chk("bp_hold2", 32'(a_out_data), 32'h011);
        chk("bp_vld_stall", 32'(a_out_valid), 32'd1);
        a_in_mode = MODE_ONES;  // changed while stalled; applies at acceptance
        a_out_ready = 1'b1;
        tick();
        chk("bp_pop1_data", 32'(a_out_data), 32'h022);
        chk("bp_rdy_back", 32'(a_in_ready), 32'd1);
        tick();
        chk("bp_pop2_data", 32'(a_out_data), 32'hF33);
        chk("bp_stream_rdy", 32'(a_in_ready), 32'd1);
        a_in_data = 8'h44; a_in_mode = MODE_ZERO;
        tick();
        a_in_valid = 1'b0;
        chk("bp_pop3_data", 32'(a_out_data), 32'h044);
        chk("bp_pop3_vld", 32'(a_out_valid), 32'd1);
        tick();
        chk("bp_drained", 32'(a_out_valid), 32'd0);

        // Asynchronous reset with two beats buffered
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'h55;
        b_in_valid = 1'b1; b_in_data = 16'h1000; b_in_mode = MODE_ZERO;
        tick();
        b_in_valid = 1'b0;
        a_in_data = 8'h66;
        tick();
        a_in_valid = 1'b0;
        chk("mid_full_rdy", 32'(a_in_ready), 32'd0);
        chk("mid_b_cnt", 32'(b_trunc_cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(a_out_valid), 32'd0);
        chk("mid_rst_rdy", 32'(a_in_ready), 32'd0);
        chk("mid_rst_data", 32'(a_out_data), 32'd0);
        chk("mid_rst_b_cnt", 32'(b_trunc_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        tick();
        chk("post_rst_vld", 32'(a_out_valid), 32'd0);
        send_a(8'h7A, MODE_ZERO, 12'h07A, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
